seg_display_ctrl: RTL and testbench

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_ctrl.sv | 112 +++++++++++
 tb/tb_seg_display_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// Eight-digit multiplexed 7-segment driver with memory-mapped display/mask registers.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_display_ctrl #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_cs,
    input  logic        io_write,
    input  logic [1:0]  low_addr,
    input  logic [31:0] wdata,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [31:0]   disp_q, disp_d;
    logic [7:0]    mask_q, mask_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          tick;
    logic [3:0]    nib;
    logic [31:0]   upper;
    logic          blank;
    logic          unused_wdata;

    assign unused_wdata = ^wdata[31:16];

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    assign tick  = (presc_q == PW'(SCAN_DIV - 1));
    assign upper = disp_q >> {idx_q, 2'b00};
    assign nib   = upper[3:0];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign blank = (idx_q != 3'd0) && (upper == 32'd0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        disp_d = disp_q;
        mask_d = mask_q;
        if (seg_cs && io_write) begin
            case (low_addr)
                2'b00:   disp_d[15:0]  = wdata[15:0];
                2'b10:   disp_d[31:16] = wdata[15:0];
                2'b01:   mask_d        = wdata[7:0];
                default: ;
            endcase
        end
    end

    // idx_q names the digit that the coming tick will display, so the first
    // tick after reset shows digit 0 before the pointer moves on.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        if (tick) begin
            idx_d = idx_q + 3'd1;
            seg_d = hex7(nib);
            an_d  = (mask_q[idx_q] && !blank) ? ~(8'h01 << idx_q) : '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q  <= '0;
            mask_q  <= '1;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
        end else begin
            disp_q  <= disp_d;
            mask_q  <= mask_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign seg_an  = an_q;
    assign seg_out = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl (SCAN_DIV=4) with a per-cycle reference model.
module tb_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seg_cs = 1'b0;
    logic        io_write = 1'b0;
    logic [1:0]  low_addr = 2'b00;
    logic [31:0] wdata = '0;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    int total = 0;
    int bad   = 0;

    seg_display_ctrl #(.SCAN_DIV(4), .DIGITS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_cs   (seg_cs),
        .io_write (io_write),
        .low_addr (low_addr),
        .wdata    (wdata),
        .seg_an   (seg_an),
        .seg_out  (seg_out)
    );

    always #5 clk = ~clk;

    // Reference model: registers, cycle counter and a digit pointer.
    logic [7:0]  hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [31:0] m_disp;
    logic [7:0]  m_mask, m_an, m_seg;
    int          m_cnt, m_k;

    function automatic logic [7:0] exp_an(input logic [31:0] d, input logic [7:0] mk, input int k);
        logic vis;
        vis = mk[k];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (k > 0 && (d >> (4 * k)) == 0) vis = 1'b0;
`endif
        return vis ? ~(8'd1 << k) : 8'hFF;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_disp <= 32'd0; m_mask <= 8'hFF; m_cnt <= 0; m_k <= 0;
            m_an <= 8'hFF; m_seg <= 8'hFF;
        end else begin
            if (m_cnt == 3) begin
                m_cnt <= 0;
                m_k   <= (m_k + 1) % 8;
                m_seg <= hex_tbl[(m_disp >> (4 * m_k)) & 32'hF];
                m_an  <= exp_an(m_disp, m_mask, m_k);
            end else begin
                m_cnt <= m_cnt + 1;
            end
            if (seg_cs && io_write) begin
                if (low_addr == 2'b00) m_disp[15:0]  <= wdata[15:0];
                if (low_addr == 2'b10) m_disp[31:16] <= wdata[15:0];
                if (low_addr == 2'b01) m_mask        <= wdata[7:0];
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_an", seg_an, m_an);
            chk("model_seg", seg_out, m_seg);
            total++;
            if ($countones(~seg_an) > 1) begin
                bad++;
                $display("FAIL onehot_an: got %h expected at most one low bit", seg_an);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_an", seg_an, 8'hFF);
        chk("rst_seg", seg_out, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        seg_cs = 1'b1; io_write = 1'b1; low_addr = a; wdata = d;
        @(posedge clk);
        #1 seg_cs = 1'b0; io_write = 1'b0; low_addr = 2'b00; wdata = '0;
    endtask

    task automatic tick_chk(input string name, input logic [7:0] an, input logic [7:0] sg);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_an"}, seg_an, an);
        chk({name, "_seg"}, seg_out, sg);
    endtask

    logic [7:0] hi_seg [4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        chk("init_an", seg_an, 8'hFF);
        chk("init_seg", seg_out, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        // First tick after release shows digit 0 of a cleared display.
        repeat (4) @(posedge clk);
        #1;
        chk("first_an", seg_an, 8'hFE);
        chk("first_seg", seg_out, 8'hC0);
        repeat (6) @(posedge clk);

        // Low half write, digits 0..3.
        do_reset();
        wr(2'b00, 32'h0000_1234);
        repeat (3) @(posedge clk);
        #1;
        chk("lo_d0_an", seg_an, 8'hFE);
        chk("lo_d0_seg", seg_out, 8'h99);
        tick_chk("lo_d1", 8'hFD, 8'hB0);
        tick_chk("lo_d2", 8'hFB, 8'hA4);
        tick_chk("lo_d3", 8'hF7, 8'hF9);

        // High half write, digits 4..7 then wrap to digit 0.
        do_reset();
        wr(2'b10, 32'h0000_ABCD);
        repeat (3) @(posedge clk);
        repeat (12) @(posedge clk);
        for (int i = 0; i < 4; i++)
            tick_chk($sformatf("hi_d%0d", i + 4), ~(8'd1 << (i + 4)), hi_seg[i]);
        tick_chk("wrap", 8'hFE, 8'hC0);

        // Mask write: only digits 0 and 2 lit.
        do_reset();
        wr(2'b00, 32'h0000_1111);
        wr(2'b01, 32'h0000_0005);
        repeat (2) @(posedge clk);
        #1;
        chk("mask_d0_an", seg_an, 8'hFE);
        chk("mask_d0_seg", seg_out, 8'hF9);
        tick_chk("mask_d1", 8'hFF, 8'hF9);
        tick_chk("mask_d2", 8'hFB, 8'hF9);
        tick_chk("mask_d3", 8'hFF, 8'hF9);

        // Gated writes: no chip select, and the reserved address.
        do_reset();
        seg_cs = 1'b0; io_write = 1'b1; low_addr = 2'b00; wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 seg_cs = 1'b1; low_addr = 2'b11; wdata = 32'h0;
        @(posedge clk);
        #1 seg_cs = 1'b0; io_write = 1'b0; low_addr = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("gate_an", seg_an, 8'hFE);
        chk("gate_seg", seg_out, 8'hC0);

        // Write landing on a tick edge only shows from the next tick.
        do_reset();
        repeat (3) @(posedge clk);
        #1 seg_cs = 1'b1; io_write = 1'b1; low_addr = 2'b00; wdata = 32'h88;
        @(posedge clk);
        #1 seg_cs = 1'b0; io_write = 1'b0; wdata = '0;
        chk("same_edge_an", seg_an, 8'hFE);
        chk("same_edge_seg", seg_out, 8'hC0);
        tick_chk("after_edge", 8'hFD, 8'h80);

`ifdef SEG_LEADING_ZERO_BLANK_EN
        do_reset();
        wr(2'b00, 32'h0000_0050);
        repeat (3) @(posedge clk);
        #1;
        chk("lz_d0_an", seg_an, 8'hFE);
        chk("lz_d0_seg", seg_out, 8'hC0);
        tick_chk("lz_d1", 8'hFD, 8'h92);
        for (int i = 2; i < 8; i++) begin
            repeat (4) @(posedge clk);
            #1 chk($sformatf("lz_d%0d_an", i), seg_an, 8'hFF);
        end
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("lz0_d0_an", seg_an, 8'hFE);
        chk("lz0_d0_seg", seg_out, 8'hC0);
        repeat (4) @(posedge clk);
        #1 chk("lz0_d1_an", seg_an, 8'hFF);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
